// File: rtl/melody_seq_ctrl.sv
// Beat sequencer for the keyboard music player: turns one-pulse key commands into
// play/pause/direction/speed state and steps the beat index off a clock-enable tick counter.
module melody_seq_ctrl #(
    parameter int SLOW_TICKS = 100_000_000,
    parameter int FAST_TICKS = 50_000_000,
    parameter int LAST_BEAT  = 14,
    parameter int IDX_W      = 4,
    parameter int CNT_W      = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_play,
    input  logic             cmd_pause,
    input  logic             cmd_restart,
    input  logic             cmd_fwd,
    input  logic             cmd_rev,
    input  logic             cmd_speed,
    output logic [IDX_W-1:0] ibeat,
    output logic             mute,
    output logic             beat_tick,
    output logic [1:0]       state,
    output logic             fast,
    output logic             reverse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_TICKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_BEAT);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] ibeat_reg, ibeat_next;
    logic             fast_reg, fast_next;
    logic             reverse_reg, reverse_next;
    logic             tick_reg, tick_next;
    logic             mute_reg;

    logic [CNT_W-1:0] period_last;
    logic [IDX_W-1:0] lim;
    logic             terminal;

    // The >= compare lets a slow-to-fast switch with a large count end the beat at once.
    assign period_last = fast_reg ? FAST_LAST : SLOW_LAST;
    assign lim         = reverse_reg ? '0 : LAST_IDX;
    assign terminal    = (cnt_reg >= period_last);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        ibeat_next   = ibeat_reg;
        fast_next    = fast_reg ^ cmd_speed;
        reverse_next = reverse_reg;
        tick_next    = 1'b0;
        if (cmd_fwd && !cmd_rev) begin
            reverse_next = 1'b0;
        end
        if (cmd_rev && !cmd_fwd) begin
            reverse_next = 1'b1;
        end

        if (cmd_restart) begin
            state_next   = ST_IDLE;
            cnt_next     = '0;
            ibeat_next   = '0;
            fast_next    = 1'b0;
            reverse_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    cnt_next = '0;
                    if (cmd_play) begin
                        state_next = ST_PLAY;
                        ibeat_next = reverse_next ? LAST_IDX : '0;
                    end
                end
                ST_PLAY: begin
                    if (cmd_pause) begin
                        state_next = ST_PAUSE;
                    end else if (terminal) begin
                        cnt_next  = '0;
                        tick_next = 1'b1;
                        if (ibeat_reg == lim) begin
                            state_next = ST_DONE;
                        end else if (reverse_reg) begin
                            ibeat_next = ibeat_reg - IDX_ONE;
                        end else begin
                            ibeat_next = ibeat_reg + IDX_ONE;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                ST_PAUSE: begin
                    if (cmd_play) begin
                        state_next = ST_PLAY;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            ibeat_reg   <= '0;
            fast_reg    <= 1'b0;
            reverse_reg <= 1'b0;
            tick_reg    <= 1'b0;
            mute_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ibeat_reg   <= ibeat_next;
            fast_reg    <= fast_next;
            reverse_reg <= reverse_next;
            tick_reg    <= tick_next;
            mute_reg    <= (state_next != ST_PLAY);
        end
    end

    assign ibeat     = ibeat_reg;
    assign mute      = mute_reg;
    assign beat_tick = tick_reg;
    assign state     = state_reg;
    assign fast      = fast_reg;
    assign reverse   = reverse_reg;

endmodule
